// File: rtl/cfg_chain_pkg.sv
// Shared types and helpers for the configuration scan chain.
package cfg_chain_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL
  } fill_state_e;

  // Bits needed to hold a bit count in the range 0..width.
  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/cfg_chain_counter.sv
// Saturating 0..WIDTH bit counter with load controls and fill-state decode.
module cfg_chain_counter
  import cfg_chain_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = count_width(WIDTH)
) (
  input  logic CK,
  input  logic RST,
  input  logic INC,
  input  logic LD0,
  input  logic LD1,
  input  logic LDW,
  output logic FULL
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  fill_state_e   fill_state;

  always_ff @(posedge CK) begin
    if (RST) count <= '0;
    else     count <= count_nxt;
  end

  // LD1 covers a commit that coincides with a shift, so it outranks INC.
  always_comb begin
    count_nxt = count;
    if (LDW)                count_nxt = CNT_MAX;
    else if (LD1)           count_nxt = CW'(1);
    else if (INC) begin
      if (count != CNT_MAX) count_nxt = count + CW'(1);
    end
    else if (LD0)           count_nxt = '0;
  end

  always_comb begin
    fill_state = ST_FILLING;
    if (count == '0)           fill_state = ST_EMPTY;
    else if (count == CNT_MAX) fill_state = ST_FULL;
  end

  assign FULL = (fill_state == ST_FULL);

endmodule

// File: rtl/cfg_shadow_scan_chain.sv
// Double-buffered configuration scan chain: serial/parallel chain plus a
// shadow register updated only by a commit of a completely filled chain.
module cfg_shadow_scan_chain
  import cfg_chain_pkg::*;
#(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             SE,
  input  logic             SI,
  input  logic             CAP,
  input  logic [WIDTH-1:0] D,
  input  logic             COMMIT,
  input  logic             CFGE,
  output logic             SO,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] CFGQ,
  output logic [WIDTH-1:0] CFGQN,
  output logic             FULL,
  output logic             ERR
);

  logic [WIDTH-1:0] chain;
  logic [WIDTH-1:0] shadow;
  logic             full;
  logic             commit_ok;
  logic             err_q;

  assign commit_ok = COMMIT & full;

  cfg_chain_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .CK   (CK),
    .RST  (RST),
    .INC  (SE & ~CAP),
    .LD0  (commit_ok),
    .LD1  (commit_ok & SE & ~CAP),
    .LDW  (CAP),
    .FULL (full)
  );

  always_ff @(posedge CK) begin
    if (RST) begin
      chain  <= RST_VAL;
      shadow <= RST_VAL;
      err_q  <= 1'b0;
    end else begin
      if (CAP)     chain <= D;
      else if (SE) chain <= {chain[WIDTH-2:0], SI};
      // Shadow takes the pre-edge chain, so a same-cycle shift is excluded.
      if (commit_ok) shadow <= chain;
      err_q <= COMMIT & ~full;
    end
  end

  assign SO    = chain[WIDTH-1];
  assign Q     = chain;
  assign FULL  = full;
  assign ERR   = err_q;
  assign CFGQ  = CFGE ? shadow  : '0;
  assign CFGQN = CFGE ? ~shadow : '1;

endmodule

// File: tb/tb_cfg_shadow_scan_chain.sv
// Self-checking bench for cfg_shadow_scan_chain (WIDTH=8, RST_VAL=8'hA5).
module tb_cfg_shadow_scan_chain;

  localparam int unsigned W  = 8;
  localparam logic [7:0]  RV = 8'hA5;

  logic       CK = 1'b0;
  logic       RST = 1'b0, SE = 1'b0, SI = 1'b0, CAP = 1'b0, COMMIT = 1'b0, CFGE = 1'b0;
  logic [7:0] D = '0;
  logic       SO, FULL, ERR;
  logic [7:0] Q, CFGQ, CFGQN;

  int nrun = 0;
  int nfail = 0;

  // Reference model: chain value, shadow value, number of valid bits loaded.
  logic [7:0] m_chain  = RV;
  logic [7:0] m_shadow = RV;
  int         m_bits   = 0;
  logic       m_err    = 1'b0;

  cfg_shadow_scan_chain #(
    .WIDTH   (W),
    .RST_VAL (RV)
  ) dut (
    .CK     (CK),
    .RST    (RST),
    .SE     (SE),
    .SI     (SI),
    .CAP    (CAP),
    .D      (D),
    .COMMIT (COMMIT),
    .CFGE   (CFGE),
    .SO     (SO),
    .Q      (Q),
    .CFGQ   (CFGQ),
    .CFGQN  (CFGQN),
    .FULL   (FULL),
    .ERR    (ERR)
  );

  always #5 CK = ~CK;

  // Drive one cycle of inputs, advance the model across the edge, sample #1 later.
  task automatic cycle(input logic rst, input logic se, input logic si,
                       input logic cap, input logic [7:0] d, input logic commit);
    logic was_full;
    @(negedge CK);
    RST = rst; SE = se; SI = si; CAP = cap; D = d; COMMIT = commit;
    @(posedge CK);
    was_full = (m_bits == int'(W));
    if (rst) begin
      m_chain = RV; m_shadow = RV; m_bits = 0; m_err = 1'b0;
    end else begin
      m_err = commit && !was_full;
      if (commit && was_full) begin
        m_shadow = m_chain;
        m_bits   = 0;
      end
      if (cap) begin
        m_chain = d;
        m_bits  = W;
      end else if (se) begin
        m_chain = 8'((int'(m_chain) * 2 + int'(si)) % 256);
        m_bits  = (m_bits + 1 > int'(W)) ? int'(W) : m_bits + 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    CFGE = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    nrun++; if (Q !== 8'hA5) begin nfail++; $display("FAIL reset_q got %h exp a5", Q); end
    nrun++; if (SO !== 1'b1) begin nfail++; $display("FAIL reset_so got %b exp 1", SO); end
    nrun++; if (FULL !== 1'b0) begin nfail++; $display("FAIL reset_full got %b exp 0", FULL); end
    nrun++; if (ERR !== 1'b0) begin nfail++; $display("FAIL reset_err got %b exp 0", ERR); end
    nrun++; if (CFGQ !== 8'h00 || CFGQN !== 8'hFF)
      begin nfail++; $display("FAIL reset_gated got %h/%h exp 00/ff", CFGQ, CFGQN); end
    CFGE = 1'b1; #1;
    nrun++; if (CFGQ !== 8'hA5 || CFGQN !== 8'h5A)
      begin nfail++; $display("FAIL reset_cfge got %h/%h exp a5/5a", CFGQ, CFGQN); end
  endtask

  task automatic test_shift_commit();
    logic [7:0] v;
    v = 8'h3C;
    CFGE = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      cycle(1'b0, 1'b1, v[i], 1'b0, 8'h00, 1'b0);
      if (i == 1) begin
        nrun++; if (FULL !== 1'b0) begin nfail++; $display("FAIL shift_full7 got %b exp 0", FULL); end
      end
    end
    nrun++; if (FULL !== 1'b1) begin nfail++; $display("FAIL shift_full8 got %b exp 1", FULL); end
    nrun++; if (Q !== 8'h3C) begin nfail++; $display("FAIL shift_q got %h exp 3c", Q); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    nrun++; if (CFGQ !== 8'h3C) begin nfail++; $display("FAIL commit_cfgq got %h exp 3c", CFGQ); end
    nrun++; if (FULL !== 1'b0) begin nfail++; $display("FAIL commit_cnt0 got %b exp 0", FULL); end
    idle();
    nrun++; if (ERR !== 1'b0) begin nfail++; $display("FAIL commit_noerr got %b exp 0", ERR); end
  endtask

  task automatic test_short_commit();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'($urandom_range(1)), 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    nrun++; if (ERR !== 1'b1) begin nfail++; $display("FAIL short_err got %b exp 1", ERR); end
    nrun++; if (CFGQ !== 8'h3C) begin nfail++; $display("FAIL short_shadow got %h exp 3c", CFGQ); end
    nrun++; if (FULL !== 1'b0) begin nfail++; $display("FAIL short_full got %b exp 0", FULL); end
    idle();
    nrun++; if (ERR !== 1'b0) begin nfail++; $display("FAIL short_errpulse got %b exp 0", ERR); end
  endtask

  task automatic test_cap();
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'hF0, 1'b0);
    nrun++; if (Q !== 8'hF0) begin nfail++; $display("FAIL cap_q got %h exp f0", Q); end
    nrun++; if (FULL !== 1'b1) begin nfail++; $display("FAIL cap_full got %b exp 1", FULL); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    nrun++; if (CFGQ !== 8'hF0) begin nfail++; $display("FAIL cap_commit got %h exp f0", CFGQ); end
  endtask

  task automatic test_commit_shift();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    nrun++; if (CFGQ !== 8'h96) begin nfail++; $display("FAIL cshift_shadow got %h exp 96", CFGQ); end
    nrun++; if (Q !== 8'h2D) begin nfail++; $display("FAIL cshift_q got %h exp 2d", Q); end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    nrun++; if (FULL !== 1'b0) begin nfail++; $display("FAIL cshift_cnt7 got %b exp 0", FULL); end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    nrun++; if (FULL !== 1'b1) begin nfail++; $display("FAIL cshift_cnt8 got %b exp 1", FULL); end
  endtask

  task automatic test_rst_mid();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    nrun++; if (Q !== 8'hA5 || CFGQ !== 8'hA5)
      begin nfail++; $display("FAIL rst_mid got q=%h cfgq=%h exp a5/a5", Q, CFGQ); end
    nrun++; if (FULL !== 1'b0 || ERR !== 1'b0)
      begin nfail++; $display("FAIL rst_mid_flags got full=%b err=%b exp 0/0", FULL, ERR); end
    idle();
    nrun++; if (ERR !== 1'b0) begin nfail++; $display("FAIL rst_mid_noerr got %b exp 0", ERR); end
  endtask

  task automatic test_cfge();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b0);
    CFGE = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    nrun++; if (CFGQ !== 8'h00 || CFGQN !== 8'hFF)
      begin nfail++; $display("FAIL cfge_off got %h/%h exp 00/ff", CFGQ, CFGQN); end
    CFGE = 1'b1; #1;
    nrun++; if (CFGQ !== 8'h7E || CFGQN !== 8'h81)
      begin nfail++; $display("FAIL cfge_on got %h/%h exp 7e/81", CFGQ, CFGQN); end
  endtask

  task automatic test_random();
    logic [7:0] eq, eqn;
    for (int n = 0; n < 400; n++) begin
      CFGE = 1'($urandom_range(1));
      cycle(1'($urandom_range(39) == 0), 1'($urandom_range(3) != 0), 1'($urandom_range(1)),
            1'($urandom_range(11) == 0), 8'($urandom), 1'($urandom_range(5) == 0));
      eq  = CFGE ? m_shadow : 8'h00;
      eqn = CFGE ? ~m_shadow : 8'hFF;
      nrun++; if (Q !== m_chain || SO !== m_chain[7])
        begin nfail++; $display("FAIL rand_chain n=%0d got q=%h so=%b exp %h", n, Q, SO, m_chain); end
      nrun++; if (FULL !== (m_bits == int'(W)))
        begin nfail++; $display("FAIL rand_full n=%0d got %b exp bits=%0d", n, FULL, m_bits); end
      nrun++; if (ERR !== m_err)
        begin nfail++; $display("FAIL rand_err n=%0d got %b exp %b", n, ERR, m_err); end
      nrun++; if (CFGQ !== eq || CFGQN !== eqn)
        begin nfail++; $display("FAIL rand_cfg n=%0d got %h/%h exp %h/%h", n, CFGQ, CFGQN, eq, eqn); end
    end
  endtask

  initial begin
    test_reset();
    test_shift_commit();
    test_short_commit();
    test_cap();
    test_commit_shift();
    test_rst_mid();
    test_cfge();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
